// File: rtl/src_reader_pkg.sv
// src_reader_pkg: shared types and default geometry for the source frame reader.
//   src_state_t : frame reader FSM states
//   pix_beat_t  : one output pixel beat {data, eol, eof}
package src_reader_pkg;
    localparam int SRC_IMG_W = 28;
    localparam int SRC_IMG_H = 28;
    localparam int SRC_PIX_W = 8;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} src_state_t;
    typedef struct packed {
        logic [SRC_PIX_W-1:0] data;
        logic                 eol;
        logic                 eof;
    } pix_beat_t;
endpackage

// File: rtl/pix_skid_fifo.sv
// pix_skid_fifo: 2-entry FIFO of pixel beats between the ROM return path and the stream output.
//   clk, rstn : clock, async active-low reset (empties the FIFO)
//   push, din : write a beat
//   pop       : remove the head beat
//   dout      : head beat
//   full, empty, count : occupancy status
module pix_skid_fifo
    import src_reader_pkg::*;
(
    input  logic      clk,
    input  logic      rstn,
    input  logic      push,
    input  logic      pop,
    input  pix_beat_t din,
    output pix_beat_t dout,
    output logic      full,
    output logic      empty,
    output logic [1:0] count
);
    pix_beat_t mem [2];
    logic      wp, rp, push_ok, pop_ok;
    assign full    = count == 2'd2;
    assign empty   = count == 2'd0;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rp];
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp     <= 1'b0;
            rp     <= 1'b0;
            count  <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (push_ok) begin
                mem[wp] <= din;
                wp      <= ~wp;
            end
            if (pop_ok) rp <= ~rp;
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end
endmodule

// File: rtl/src_frame_reader.sv
// src_frame_reader: reads one frame from the source ROM in raster order on go and streams it out.
//   clk, rstn          : clock, async active-low reset (aborts any frame)
//   go                 : start pulse, honoured in IDLE or DONE
//   ready              : one-cycle pulse once the eof beat has been accepted
//   busy               : frame in progress (RUN or DRAIN)
//   rom_rd, rom_addr   : ROM read strobe and address (row*IMG_W + col)
//   rom_q              : ROM data, one cycle after rom_rd
//   pix_valid/ready    : output handshake
//   pix_data/eol/eof   : output beat
//   Macro SRC_PAD_EN   : stream a 1-pixel zero border around the image
module src_frame_reader
    import src_reader_pkg::*;
#(
    parameter int IMG_W  = SRC_IMG_W,
    parameter int IMG_H  = SRC_IMG_H,
    parameter int PIX_W  = SRC_PIX_W,
    parameter int ADDR_W = 10
)(
    input  logic              clk,
    input  logic              rstn,
    input  logic              go,
    output logic              ready,
    output logic              busy,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_q,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_eol,
    output logic              pix_eof
);
`ifdef SRC_PAD_EN
    localparam int SW = IMG_W + 2;
    localparam int SH = IMG_H + 2;
`else
    localparam int SW = IMG_W;
    localparam int SH = IMG_H;
`endif
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(SW - 1);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(SH - 1);
    src_state_t        state, state_nx;
    logic [ADDR_W-1:0] row, col;
    logic              start, issue, last, border, pop, v_q, pad_q, eol_q, eof_q;
    logic              full, empty;
    logic [1:0]        count;
    pix_beat_t         din, head;
`ifdef SRC_PAD_EN
    // border positions take a pipeline slot like a read but never touch the ROM
    assign border   = row == '0 || row == LAST_ROW || col == '0 || col == LAST_COL;
    assign rom_addr = border ? '0 : ADDR_W'((row - 1) * IMG_W + col - 1);
`else
    assign border   = 1'b0;
    assign rom_addr = ADDR_W'(row * IMG_W + col);
`endif
    assign start     = go && (state == IDLE || state == DONE);
    assign last      = row == LAST_ROW && col == LAST_COL;
    assign pix_valid = !empty;
    assign pop       = pix_valid && pix_ready;
    // a slot is granted only if the FIFO can absorb it together with the read already in flight;
    // a pop this cycle frees an entry in time for the returning data
    assign issue     = state == RUN && (pop || (!full && count + {1'b0, v_q} < 2'd2));
    assign rom_rd    = issue && !border;
    assign pix_data  = pix_valid ? PIX_W'(head.data) : '0;
    assign pix_eol   = pix_valid && head.eol;
    assign pix_eof   = pix_valid && head.eof;
    assign din       = '{data: pad_q ? '0 : SRC_PIX_W'(rom_q), eol: eol_q, eof: eof_q};
    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE:    state_nx = go ? RUN : IDLE;
            RUN:     begin
                busy     = 1'b1;
                state_nx = issue && last ? DRAIN : RUN;
            end
            DRAIN:   begin
                busy     = 1'b1;
                state_nx = pop && head.eof ? DONE : DRAIN;
            end
            DONE:    begin
                ready    = 1'b1;
                state_nx = go ? RUN : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row <= '0;
            col <= '0;
        end else if (start) begin
            row <= '0;
            col <= '0;
        end else if (issue && !last) begin
            col <= col == LAST_COL ? '0 : col + 1'b1;
            if (col == LAST_COL) row <= row + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_q   <= 1'b0;
            pad_q <= 1'b0;
            eol_q <= 1'b0;
            eof_q <= 1'b0;
        end else begin
            v_q   <= issue;
            pad_q <= border;
            eol_q <= col == LAST_COL;
            eof_q <= last;
        end
    end
    pix_skid_fifo u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (v_q),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
endmodule

// File: tb/tb_src_frame_reader.sv
// tb_src_frame_reader: directed bench for src_frame_reader with a registered ROM model.
module tb_src_frame_reader;
    localparam int W = 28;
    localparam int H = 28;
`ifdef SRC_PAD_EN
    localparam int PAD = 1;
`else
    localparam int PAD = 0;
`endif
    localparam int SW = W + 2 * PAD;
    localparam int SH = H + 2 * PAD;
    localparam int NB = SW * SH;
    localparam int NR = W * H;
    localparam int FR = NB + 3;
    logic       clk = 1'b0, rstn = 1'b1, go = 1'b0, pix_ready = 1'b1;
    logic       ready, busy, rom_rd, pix_valid, pix_eol, pix_eof;
    logic [9:0] rom_addr;
    logic [7:0] rom_q = '0, pix_data;
    logic [7:0] mem [1024];
    int         n_pass = 0, n_chk = 0;
    always #5 clk = ~clk;
    src_frame_reader dut (
        .clk       (clk),
        .rstn      (rstn),
        .go        (go),
        .ready     (ready),
        .busy      (busy),
        .rom_rd    (rom_rd),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .pix_eol   (pix_eol),
        .pix_eof   (pix_eof)
    );
    always @(posedge clk) if (rom_rd) rom_q <= mem[rom_addr];
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    function automatic logic [23:0] outs();
        return {ready, busy, rom_rd, rom_addr, pix_valid, pix_data, pix_eol, pix_eof};
    endfunction
    function automatic logic [9:0] exp_beat(input int k);
        int r, c;
        logic [7:0] d;
        r = k / SW;
        c = k % SW;
        if (PAD != 0) d = (r == 0 || r == SH - 1 || c == 0 || c == SW - 1) ? 8'h00 : mem[(r - 1) * W + c - 1];
        else d = mem[k];
        return {d, c == SW - 1, k == NB - 1};
    endfunction
    task automatic fill(input bit ff);
        for (int i = 0; i < 1024; i++) mem[i] = ff ? 8'hFF : 8'(i);
    endtask
    task automatic run(input int frames, input bit rnd, input int go_at, input int rst_at);
        int cyc = 0, go_cyc = 0, beats = 0, rds = 0, readies = 0, done = 0;
        bit hold = 0, prev_rdy = 0, poked = 0;
        logic [9:0] held = '0;
        @(posedge clk);
        #1 go = 1'b1;
        pix_ready = 1'b1;
        while (done < frames) begin
            @(posedge clk);
            cyc++;
            #1 go = 1'b0;
            pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (cyc - go_cyc == 1) begin
                chk("busy_on", busy, 1);
                chk("rd_first", {rom_rd, rom_addr}, {PAD == 0, 10'd0});
            end
            if (cyc - go_cyc == 2) chk("valid_early", pix_valid, 0);
            if (cyc - go_cyc == 3) chk("valid_first", pix_valid, 1);
            chk("fifo_occ", dut.u_fifo.count <= 2'd2, 1);
            if (hold) chk("hold", {pix_valid, pix_data, pix_eol, pix_eof}, {1'b1, held});
            hold = pix_valid && !pix_ready;
            held = {pix_data, pix_eol, pix_eof};
            if (prev_rdy) chk("ready_pulse", ready, 0);
            prev_rdy = ready;
            if (rom_rd) rds++;
            if (pix_valid && pix_ready) begin
                chk("beat", {pix_data, pix_eol, pix_eof}, exp_beat(beats));
                beats++;
            end
            if (go_at >= 0 && !poked && beats == go_at) begin
                chk("busy_mid", busy, 1);
                go = 1'b1;
                poked = 1;
            end
            if (rst_at >= 0 && beats == rst_at) begin
                rstn = 1'b0;
                #1 chk("rst_outs", outs(), 0);
                repeat (2) @(posedge clk);
                #1 chk("rst_hold", outs(), 0);
                rstn = 1'b1;
                repeat (3) begin
                    @(posedge clk);
                    #1 chk("abort_idle", {ready, busy, pix_valid}, 0);
                end
                chk("abort_noready", readies, 0);
                return;
            end
            if (ready) begin
                readies++;
                done++;
                chk("busy_off", busy, 0);
                if (!rnd) chk("latency", cyc - go_cyc, FR);
                chk("beats", beats, NB);
                chk("rom_rd_cnt", rds, NR);
                beats = 0;
                rds = 0;
                if (done < frames) begin
                    go = 1'b1;
                    go_cyc = cyc;
                end
            end
            if (cyc > frames * FR * 4) begin
                chk("timeout", done, frames);
                return;
            end
        end
        @(posedge clk);
        #2 chk("idle_after", {ready, busy, pix_valid}, 0);
        chk("ready_cnt", readies, frames);
    endtask
    initial begin
        fill(0);
        #1 rstn = 1'b0;
        #1 chk("reset", outs(), 0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        run(1, 0, -1, -1);
        run(1, 1, -1, -1);
        run(1, 0, 100, -1);
        run(1, 0, -1, 400);
        run(1, 0, -1, -1);
        run(2, 0, -1, -1);
`ifdef SRC_PAD_EN
        fill(1);
        run(1, 0, -1, -1);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
